// File: rtl/hitchhike_tag_decoder.sv
// HitchHike receive-side tag decoder: aligns original and backscatter DBPSK streams,
// XORs paired symbols and majority-votes each group into a tag bit. Optional: HITCHHIKE_TAG_DEC_CONF_EN.
module hitchhike_tag_decoder #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SKIP_SYMS    = 192,
  parameter int unsigned SYMS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pkt_start,
  input  logic             pkt_end,
  input  logic             orig_bit,
  input  logic             orig_valid,
  input  logic             bs_bit,
  input  logic             bs_valid,
  output logic             tag_bit,
  output logic             tag_valid,
  output logic [CNT_W-1:0] tag_count,
  output logic             busy,
  output logic             pkt_done,
`ifdef HITCHHIKE_TAG_DEC_CONF_EN
  output logic [7:0]       tag_conf,
  output logic             low_conf,
`endif
  output logic             overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = (SKIP_SYMS > 0) ? $clog2(SKIP_SYMS + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSkip, StDecode, StDrain} state_e;

  state_e                state_q;
  logic [FIFO_DEPTH-1:0] o_mem_q, b_mem_q;
  logic [AW:0]           o_wr_q, o_rd_q, b_wr_q, b_rd_q;
  logic [SW-1:0]         skip_cnt_q;
  logic [7:0]            ones_q, sym_q;

  logic          o_empty, b_empty, o_full, b_full;
  logic          capture, pop, o_push, b_push, drop, chip;
  logic          skip_done, decoding, group_done, vote;
  logic [SW-1:0] skip_nxt;
  logic [7:0]    ones_nxt, sym_nxt, conf_nxt;
  logic [8:0]    ones_x2;

  always_comb begin
    o_empty    = (o_wr_q == o_rd_q);
    b_empty    = (b_wr_q == b_rd_q);
    o_full     = (o_wr_q[AW] != o_rd_q[AW]) && (o_wr_q[AW-1:0] == o_rd_q[AW-1:0]);
    b_full     = (b_wr_q[AW] != b_rd_q[AW]) && (b_wr_q[AW-1:0] == b_rd_q[AW-1:0]);
    capture    = ((state_q == StSkip) || (state_q == StDecode)) && !pkt_start;
    pop        = (state_q != StIdle) && !pkt_start && !o_empty && !b_empty;
    // A full FIFO still accepts a write in a cycle where it is also popped.
    o_push     = capture && orig_valid && (!o_full || pop);
    b_push     = capture && bs_valid && (!b_full || pop);
    drop       = capture && ((orig_valid && o_full && !pop) || (bs_valid && b_full && !pop));
    chip       = o_mem_q[o_rd_q[AW-1:0]] ^ b_mem_q[b_rd_q[AW-1:0]];
    skip_done  = (skip_cnt_q == SW'(SKIP_SYMS));
    skip_nxt   = skip_cnt_q + SW'(1);
    decoding   = pop && skip_done;
    ones_nxt   = ones_q + 8'(chip);
    sym_nxt    = sym_q + 8'd1;
    group_done = decoding && (sym_nxt == 8'(SYMS_PER_BIT));
    ones_x2    = {ones_nxt, 1'b0};
    vote       = (ones_x2 > 9'(SYMS_PER_BIT));
    conf_nxt   = vote ? ones_nxt : (8'(SYMS_PER_BIT) - ones_nxt);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      o_mem_q    <= '0;
      b_mem_q    <= '0;
      o_wr_q     <= '0;
      o_rd_q     <= '0;
      b_wr_q     <= '0;
      b_rd_q     <= '0;
      skip_cnt_q <= '0;
      ones_q     <= '0;
      sym_q      <= '0;
      tag_bit    <= 1'b0;
      tag_valid  <= 1'b0;
      tag_count  <= '0;
      pkt_done   <= 1'b0;
      overflow   <= 1'b0;
`ifdef HITCHHIKE_TAG_DEC_CONF_EN
      tag_conf   <= '0;
      low_conf   <= 1'b0;
`endif
    end else begin
      tag_valid <= 1'b0;
      pkt_done  <= 1'b0;
      if (o_push) begin
        o_mem_q[o_wr_q[AW-1:0]] <= orig_bit;
        o_wr_q                  <= o_wr_q + PW'(1);
      end
      if (b_push) begin
        b_mem_q[b_wr_q[AW-1:0]] <= bs_bit;
        b_wr_q                  <= b_wr_q + PW'(1);
      end
      if (pop) begin
        o_rd_q <= o_rd_q + PW'(1);
        b_rd_q <= b_rd_q + PW'(1);
      end
      if (drop) overflow <= 1'b1;

      if (pkt_start) begin
        // Restart wins over everything else, including a coincident pkt_end.
        o_wr_q     <= '0;
        o_rd_q     <= '0;
        b_wr_q     <= '0;
        b_rd_q     <= '0;
        skip_cnt_q <= '0;
        ones_q     <= '0;
        sym_q      <= '0;
        tag_count  <= '0;
        overflow   <= 1'b0;
`ifdef HITCHHIKE_TAG_DEC_CONF_EN
        low_conf   <= 1'b0;
`endif
        state_q    <= (SKIP_SYMS == 0) ? StDecode : StSkip;
      end else begin
        if (pop && !skip_done) skip_cnt_q <= skip_nxt;
        if (decoding) begin
          if (group_done) begin
            tag_valid <= 1'b1;
            tag_bit   <= vote;
            ones_q    <= '0;
            sym_q     <= '0;
            if (tag_count != '1) tag_count <= tag_count + CNT_W'(1);
`ifdef HITCHHIKE_TAG_DEC_CONF_EN
            tag_conf  <= conf_nxt;
            if (conf_nxt < 8'(SYMS_PER_BIT)) low_conf <= 1'b1;
`endif
          end else begin
            ones_q <= ones_nxt;
            sym_q  <= sym_nxt;
          end
        end
        unique case (state_q)
          StSkip: begin
            if (pkt_end) state_q <= StDrain;
            else if (pop && (skip_nxt == SW'(SKIP_SYMS))) state_q <= StDecode;
          end
          StDecode: if (pkt_end) state_q <= StDrain;
          StDrain: begin
            if (o_empty || b_empty) begin
              state_q  <= StIdle;
              pkt_done <= 1'b1;
              o_wr_q   <= '0;
              o_rd_q   <= '0;
              b_wr_q   <= '0;
              b_rd_q   <= '0;
              ones_q   <= '0;
              sym_q    <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
